// File: rtl/coloring_gen_if.sv
// Request and output handshake bundle for coloring_gen.
// The master side is the pattern source plus sink; the slave side is the generator.
interface coloring_gen_if;
  logic       req_valid;
  logic [1:0] req_color;
  logic       req_ready;
  logic       out_valid;
  logic [1:0] out_color;
  logic       out_ready;

  modport master (
    output req_valid, req_color, out_ready,
    input  req_ready, out_valid, out_color
  );

  modport slave (
    input  req_valid, req_color, out_ready,
    output req_ready, out_valid, out_color
  );
endinterface

// File: rtl/coloring_gen.sv
// Colour stream generator: emits requested colours, inserting one filler when a request breaks the rules.
// One-cycle latency through a single registered slot. Optional macro COLORGEN_BREAK_FILL_EN makes every filler 2'b11.
module coloring_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  coloring_gen_if.slave    bus,
  output logic [CNT_W-1:0] filler_cnt
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RED   = 2'd1,
    ST_GREEN = 2'd2,
    ST_BLUE  = 2'd3
  } hist_e;

  localparam logic [1:0] C_RED   = 2'b00;
  localparam logic [1:0] C_GREEN = 2'b01;
  localparam logic [1:0] C_BLUE  = 2'b10;
  localparam logic [1:0] C_BREAK = 2'b11;

  hist_e            state_q, state_d;
  logic [1:0]       run_q, run_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_color_q, out_color_d;
  logic [CNT_W-1:0] filler_cnt_q, filler_cnt_d;

  logic       slot_free;
  logic       legal;
  logic       load;
  logic [1:0] cur_color;
  logic [1:0] filler;
  logic [1:0] sym;

  always_comb begin
    cur_color = C_BREAK;
    case (state_q)
      ST_RED:   cur_color = C_RED;
      ST_GREEN: cur_color = C_GREEN;
      ST_BLUE:  cur_color = C_BLUE;
      default:  cur_color = C_BREAK;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    if (bus.req_color != C_BREAK && state_q != ST_INIT) begin
      if (bus.req_color == cur_color && run_q == 2'd2)
        legal = 1'b0;
      else if (state_q == ST_RED && bus.req_color == C_GREEN)
        legal = 1'b0;
      else if (state_q == ST_GREEN && bus.req_color == C_RED)
        legal = 1'b0;
    end
  end

  // Blue never conflicts with a red/green history; only a saturated blue run needs a break.
  always_comb begin
`ifdef COLORGEN_BREAK_FILL_EN
    filler = C_BREAK;
`else
    filler = (state_q == ST_RED || state_q == ST_GREEN) ? C_BLUE : C_BREAK;
`endif
  end

  assign slot_free = !out_valid_q || bus.out_ready;
  assign load      = slot_free && bus.req_valid;
  assign sym       = legal ? bus.req_color : filler;

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    out_valid_d  = out_valid_q;
    out_color_d  = out_color_q;
    filler_cnt_d = filler_cnt_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_color_d = sym;
      if (!legal && filler_cnt_q != {CNT_W{1'b1}})
        filler_cnt_d = filler_cnt_q + 1'b1;
      if (sym == C_BREAK) begin
        state_d = ST_INIT;
        run_d   = 2'd0;
      end else if (state_q != ST_INIT && sym == cur_color) begin
        run_d = run_q + 2'd1;
      end else begin
        run_d = 2'd1;
        case (sym)
          C_RED:   state_d = ST_RED;
          C_GREEN: state_d = ST_GREEN;
          default: state_d = ST_BLUE;
        endcase
      end
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      run_q        <= 2'd0;
      out_valid_q  <= 1'b0;
      out_color_q  <= C_BREAK;
      filler_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      out_valid_q  <= out_valid_d;
      out_color_q  <= out_color_d;
      filler_cnt_q <= filler_cnt_d;
    end
  end

  // Gated by rst_n so nothing is handed over while the block is held in reset.
  assign bus.req_ready = rst_n && slot_free && bus.req_valid && legal;
  assign bus.out_valid = out_valid_q;
  assign bus.out_color = out_color_q;
  assign filler_cnt    = filler_cnt_q;

endmodule
